data_mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port word-addressed data memory between two requesters, for example the CPU load/store unit (port 0) and a loader/DMA engine (port 1). It accepts valid/ready requests, registers the winning command, and drives the memory's read/write controls for exactly one cycle. It then returns a registered response with error flagging to the issuing port. It sits between the requesters and the data memory, which it drives directly.

---
 rtl/data_mem_arbiter_pkg.sv | 41 ++++
 rtl/data_mem_arbiter_if.sv | 41 ++++
 rtl/data_mem_arbiter_rr_arbiter2.sv | 33 +++
 rtl/data_mem_arbiter.sv | 107 ++++++++++
 tb/tb_data_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arb_pkg
//  Description : Shared types for the two-port data memory arbiter: slot
//                states, the command record and the address check helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arb_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    localparam int NUM_PORTS  = 2;

    // Per-port transaction slot: waiting, memory strobe cycle, response held
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } slot_state_t;

    // Winning request as latched on grant; err is decided at accept time
    typedef struct packed {
        logic                  valid;
        logic                  id;
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic                  err;
    } cmd_t;

    // Misaligned or beyond the last word; compared two bits wider so the
    // byte limit cannot wrap
    function automatic logic addr_err(input logic [CMD_ADDR_W-1:0] addr,
                                      input int unsigned           depth_words);
        logic [CMD_ADDR_W+1:0] limit;
        limit = (CMD_ADDR_W+2)'(depth_words) << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter_if
//  Description : Request/response channels of both requesters plus the data
//                memory control bus seen by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_PORTS-1:0]             req_valid;
    logic [NUM_PORTS-1:0]             req_write;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]             req_ready;
    logic [NUM_PORTS-1:0]             rsp_valid;
    logic [NUM_PORTS-1:0]             rsp_ready;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_rdata;
    logic [NUM_PORTS-1:0]             rsp_err;
    logic                             mem_read;
    logic                             mem_write;
    logic [ADDR_W-1:0]                mem_address;
    logic [DATA_W-1:0]                mem_wdata;
    logic [DATA_W-1:0]                mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_read, mem_write, mem_address, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter with a combinational one-hot
//                grant; on a tie the port that did not win last is served.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);
    logic r_last_grant;

    // Single requester wins outright; a tie goes to the other port than last time
    always_comb begin
        gnt = elig;
        if (elig == 2'b11) begin
            gnt = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Remember the most recent winner; reset favours port 0 on the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (gnt != 2'b00) begin
            r_last_grant <= gnt[1];
        end
    end
endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Shares one single-port data memory between two valid/ready
//                requesters. One command register feeds the memory for a
//                single cycle; each port owns a registered response.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int          ADDR_W      = CMD_ADDR_W,
    parameter int          DATA_W      = CMD_DATA_W,
    parameter int unsigned DEPTH_WORDS = 8192
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_arbiter_if.slave   bus
);
    slot_state_t                      r_slot [NUM_PORTS];
    cmd_t                             r_cmd;
    logic [NUM_PORTS-1:0][DATA_W-1:0] r_rsp_rdata;
    logic [NUM_PORTS-1:0]             r_rsp_err;
    logic [ADDR_W-1:0]                r_hold_address;
    logic [DATA_W-1:0]                r_hold_wdata;

    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_gnt;
    logic                 w_gnt_id;
    cmd_t                 w_new_cmd;
    logic                 w_cmd_live;
    logic [DATA_W-1:0]    w_rsp_data;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            // A port competes only with an empty slot; nothing is granted in reset
            assign w_elig[gi]        = !rst && (r_slot[gi] == IDLE) && bus.req_valid[gi];
            assign bus.rsp_valid[gi] = (r_slot[gi] == RSP);
        end
    endgenerate

    rr_arbiter2 u_rr_arbiter2 (
        .clk  (clk),
        .rst  (rst),
        .elig (w_elig),
        .gnt  (w_gnt)
    );

    assign bus.req_ready = w_gnt;
    assign w_gnt_id      = w_gnt[1];

    // Latch candidate built from the winning port's request fields
    always_comb begin
        w_new_cmd       = '0;
        w_new_cmd.valid = |w_gnt;
        w_new_cmd.id    = w_gnt_id;
        w_new_cmd.write = bus.req_write[w_gnt_id];
        w_new_cmd.addr  = bus.req_addr[w_gnt_id];
        w_new_cmd.wdata = bus.req_wdata[w_gnt_id];
        w_new_cmd.err   = addr_err(bus.req_addr[w_gnt_id], DEPTH_WORDS);
    end

    // Erroring commands and the reset cycle never strobe the memory
    assign w_cmd_live      = r_cmd.valid && !r_cmd.err && !rst;
    assign bus.mem_read    = w_cmd_live && !r_cmd.write;
    assign bus.mem_write   = w_cmd_live && r_cmd.write;
    assign bus.mem_address = w_cmd_live ? r_cmd.addr  : r_hold_address;
    assign bus.mem_wdata   = w_cmd_live ? r_cmd.wdata : r_hold_wdata;

    // Read data is only trusted while the memory is actively driving it
    assign w_rsp_data    = bus.mem_read ? bus.mem_rdata : '0;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // Slot FSMs, command register, response registers and address/data hold
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_slot[i[0]] <= IDLE;
            end
            r_cmd          <= '0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= '0;
            r_hold_address <= '0;
            r_hold_wdata   <= '0;
        end else begin
            r_cmd <= w_new_cmd;
            if (w_cmd_live) begin
                r_hold_address <= r_cmd.addr;
                r_hold_wdata   <= r_cmd.wdata;
            end
            if (r_cmd.valid) begin
                r_rsp_rdata[r_cmd.id] <= w_rsp_data;
                r_rsp_err[r_cmd.id]   <= r_cmd.err;
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                case (r_slot[i[0]])
                    IDLE:    if (w_gnt[i[0]]) r_slot[i[0]] <= CMD;
                    CMD:     r_slot[i[0]] <= RSP;
                    RSP:     if (bus.rsp_ready[i[0]]) r_slot[i[0]] <= IDLE;
                    default: r_slot[i[0]] <= IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Self-checking bench for data_mem_arbiter: directed vector
//                table, tie/backpressure/reset sequences and a randomized run
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
    localparam int          DEPTH   = 8192;
    localparam logic [31:0] FLOATING = 32'hBAD0_BAD0;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_0000;
    endfunction

    // Memory model: combinational read, a fixed junk pattern when not read
    logic [31:0] tb_mem [DEPTH];
    bit          mem_loaded;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_write) begin
            tb_mem[bus.mem_address[14:2]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = bus.mem_read ? tb_mem[bus.mem_address[14:2]] : FLOATING;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 2'b11;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_idle();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        checkw({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        checkw({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        checkw({tag, "_rsp_rdata0"}, bus.rsp_rdata[0], 32'd0);
        checkw({tag, "_rsp_rdata1"}, bus.rsp_rdata[1], 32'd0);
        checkw({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        checkw({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        checkw({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
        checkw({tag, "_mem_address"}, bus.mem_address, 32'd0);
        checkw({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    // One complete transaction on port p with rsp_ready held high
    task automatic run_txn(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int nrd, output int nwr,
                           output logic [31:0] saddr, output logic [31:0] swdata);
        int n;
        @(negedge clk);
        bus.req_valid[p] = 1'b1;
        bus.req_write[p] = w;
        bus.req_addr[p]  = a;
        bus.req_wdata[p] = d;
        #1;
        n = 0;
        while (!bus.req_ready[p] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checkw("accept_bound", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        nrd = 0; nwr = 0; lat = 0; saddr = '0; swdata = '0; rd = '0; er = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            if (bus.mem_read)  begin nrd++; saddr = bus.mem_address; end
            if (bus.mem_write) begin nwr++; saddr = bus.mem_address; swdata = bus.mem_wdata; end
            if (bus.rsp_valid[p]) begin
                lat = k;
                rd  = bus.rsp_rdata[p];
                er  = bus.rsp_err[p];
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Both ports raise a load together; first is the expected one-hot winner
    task automatic tie_round(input logic [1:0] first, input string tag);
        logic [1:0] second;
        second = ~first;
        @(negedge clk);
        bus.req_valid   = 2'b11;
        bus.req_write   = 2'b00;
        bus.req_addr[0] = 32'h10;
        bus.req_addr[1] = 32'h40;
        #1;
        checkw({tag, "_first"}, 32'(bus.req_ready), 32'(first));
        @(posedge clk); #1;
        bus.req_valid = bus.req_valid & second;
        @(negedge clk); #1;
        checkw({tag, "_second"}, 32'(bus.req_ready), 32'(second));
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
    endtask

    typedef struct {
        bit          port;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return ($urandom_range(0, 31) << 2) | $urandom_range(1, 3);
        if (r == 1) return $urandom_range(32'h8000, 32'hFFFF_FFFF) & 32'hFFFF_FFFC;
        if (r == 2) return 32'h7FFC;
        return $urandom_range(0, 31) << 2;
    endfunction

    function automatic bit ref_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    vec_t        vecs [10];
    logic [31:0] ref_mem [DEPTH];

    initial begin
        logic [31:0] rd, saddr, swdata, hold_rd;
        logic        er;
        int          lat, nrd, nwr;
        int          acc1 [$];
        bit          busy [2];
        bit          ev [2];
        int          acc_t [2];
        logic [31:0] exp_rd [2];
        logic [31:0] exp_a [2];
        logic [31:0] exp_d [2];
        bit          exp_er [2];
        bit          exp_w [2];
        int          lg;
        logic [1:0]  v, rr, elig, eg;
        bit          erd, ewr;
        logic [31:0] eaddr, ewd;
        logic [12:0] idx;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_8000, 32'h0,         1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_7FFC, 32'h0,         1'b0, init_word(8191)};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_7FFC, 32'h1234_5678, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_7FFC, 32'h0,         1'b0, 32'h1234_5678};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0002, 32'h5555_AAAA, 1'b1, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, init_word(0)};
        vecs[9] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};

        // Reset: requests during reset are never accepted
        rst = 1'b1;
        set_idle();
        bus.req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkw("reset_req_ready_in_rst", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = 2'b00;
        @(negedge clk); #1;
        check_reset_state("reset");

        // Directed single transactions
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].port, vecs[i].write, vecs[i].addr, vecs[i].wdata,
                    rd, er, lat, nrd, nwr, saddr, swdata);
            checkw($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            checkw($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkw($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            checkw($sformatf("v%0d_reads", i), 32'(nrd), 32'(!vecs[i].write && !vecs[i].exp_err));
            checkw($sformatf("v%0d_writes", i), 32'(nwr), 32'(vecs[i].write && !vecs[i].exp_err));
            if (!vecs[i].exp_err)
                checkw($sformatf("v%0d_address", i), saddr, vecs[i].addr);
            if (vecs[i].write && !vecs[i].exp_err)
                checkw($sformatf("v%0d_wdata", i), swdata, vecs[i].wdata);
        end

        // Round-robin ties: fresh reset favours port 0
        do_reset();
        tie_round(2'b01, "tie1");
        tie_round(2'b01, "tie2");
        run_txn(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr, saddr, swdata);
        checkw("solo_rdata", rd, 32'hDEAD_BEEF);
        tie_round(2'b10, "tie3");

        // Port 0 stalls its response while port 1 keeps streaming
        @(negedge clk);
        bus.rsp_ready[0] = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_write[0] = 1'b0;
        bus.req_addr[0]  = 32'h10;
        #1;
        checkw("bp_accept0", 32'(bus.req_ready[0]), 32'd1);
        @(posedge clk); #1;
        bus.req_addr[0]  = 32'h14;
        bus.req_valid[1] = 1'b1;
        bus.req_write[1] = 1'b0;
        bus.req_addr[1]  = 32'h44;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); #1;
            checkw("bp_ready0", 32'(bus.req_ready[0]), 32'd0);
            if (k >= 2) begin
                checkw("bp_valid0", 32'(bus.rsp_valid[0]), 32'd1);
                checkw("bp_rdata0", bus.rsp_rdata[0], 32'hDEAD_BEEF);
            end
            if (bus.req_ready[1]) acc1.push_back(k);
        end
        checkw("bp_p1_count", 32'(acc1.size()), 32'd4);
        for (int j = 1; j < acc1.size(); j++)
            checkw("bp_p1_spacing", 32'(acc1[j] - acc1[j-1]), 32'd3);
        @(negedge clk);
        bus.req_valid    = 2'b00;
        bus.rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        checkw("bp_release", 32'(bus.rsp_valid[0]), 32'd0);
        repeat (3) @(posedge clk);

        // Reset lands in the strobe cycle of a store
        @(negedge clk);
        bus.req_valid[0] = 1'b1;
        bus.req_write[0] = 1'b1;
        bus.req_addr[0]  = 32'h20;
        bus.req_wdata[0] = 32'hCAFE_F00D;
        #1;
        checkw("rstmid_accept", 32'(bus.req_ready[0]), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        checkw("rstmid_mem_write", 32'(bus.mem_write), 32'd0);
        checkw("rstmid_mem_read", 32'(bus.mem_read), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        @(negedge clk); #1;
        check_reset_state("rstmid");
        checkw("rstmid_memword", tb_mem[8], init_word(8));

        // Randomized traffic against the transaction-level reference model
        do_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = tb_mem[i];
        lg = 1;
        for (int i = 0; i < 2; i++) busy[i] = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                bus.req_valid[i[0]] = ($urandom_range(0, 2) != 0);
                bus.req_write[i[0]] = 1'($urandom_range(0, 1));
                bus.req_addr[i[0]]  = rand_addr();
                bus.req_wdata[i[0]] = $urandom();
                bus.rsp_ready[i[0]] = ($urandom_range(0, 3) != 0);
            end
            #1;
            v  = bus.req_valid;
            rr = bus.rsp_ready;
            for (int i = 0; i < 2; i++) elig[i[0]] = !busy[i] && v[i[0]];
            if (elig == 2'b11) eg = (lg == 1) ? 2'b01 : 2'b10;
            else               eg = elig;
            checkw("rnd_req_ready", 32'(bus.req_ready), 32'(eg));

            erd = 1'b0; ewr = 1'b0; eaddr = '0; ewd = '0;
            for (int i = 0; i < 2; i++) begin
                if (busy[i] && acc_t[i] == t && !exp_er[i]) begin
                    if (exp_w[i]) ewr = 1'b1;
                    else          erd = 1'b1;
                    eaddr = exp_a[i];
                    ewd   = exp_d[i];
                end
            end
            checkw("rnd_mem_read", 32'(bus.mem_read), 32'(erd));
            checkw("rnd_mem_write", 32'(bus.mem_write), 32'(ewr));
            if (erd || ewr) checkw("rnd_mem_address", bus.mem_address, eaddr);
            if (ewr)        checkw("rnd_mem_wdata", bus.mem_wdata, ewd);

            for (int i = 0; i < 2; i++) begin
                ev[i] = busy[i] && (t >= acc_t[i] + 1);
                checkw($sformatf("rnd_rsp_valid%0d", i), 32'(bus.rsp_valid[i[0]]), 32'(ev[i]));
                if (ev[i]) begin
                    checkw($sformatf("rnd_rsp_rdata%0d", i), bus.rsp_rdata[i[0]], exp_rd[i]);
                    checkw($sformatf("rnd_rsp_err%0d", i), 32'(bus.rsp_err[i[0]]), 32'(exp_er[i]));
                end
            end

            // Advance the model across the coming clock edge
            for (int i = 0; i < 2; i++)
                if (ev[i] && rr[i[0]]) busy[i] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (eg[i[0]]) begin
                    busy[i]   = 1'b1;
                    acc_t[i]  = t + 1;
                    exp_w[i]  = bus.req_write[i[0]];
                    exp_a[i]  = bus.req_addr[i[0]];
                    exp_d[i]  = bus.req_wdata[i[0]];
                    exp_er[i] = ref_err(exp_a[i]);
                    idx       = exp_a[i][14:2];
                    if (!exp_er[i] && exp_w[i]) ref_mem[idx] = exp_d[i];
                    exp_rd[i] = (!exp_er[i] && !exp_w[i]) ? ref_mem[idx] : 32'h0;
                    lg        = i;
                end
            end
        end
        hold_rd = '0;
        @(negedge clk);
        set_idle();
        repeat (5) @(posedge clk);
        checkw("drain_rsp_valid", 32'(bus.rsp_valid), 32'(hold_rd[1:0]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
